// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file.
//   reg_idx_e      : full-register names (AX..DI) for the 8-register build.
//   reg8_idx_e     : 8-bit alias names (AL..BH); the selector MSB picks the high byte.
//   phys_reg()     : maps (selector, 8-bit mode) to the physical register index.
//   byte_lane_mask : which of the two low byte lanes an 8-bit access touches.
package regfile_pkg;

   typedef enum logic [2:0] {AX, CX, DX, BX, SP, BP, SI, DI} reg_idx_e;
   typedef enum logic [2:0] {AL, CL, DL, BL, AH, CH, DH, BH} reg8_idx_e;

   // 8-bit selectors alias the lower half of the file: the selector MSB is a
   // byte select, not part of the register index.
   function automatic int unsigned phys_reg(input int unsigned sel,
                                            input logic        is_8_bit,
                                            input int unsigned sel_w);
      int unsigned lo_mask;
      lo_mask = (32'd1 << (sel_w - 1)) - 32'd1;
      return is_8_bit ? (sel & lo_mask) : sel;
   endfunction

   function automatic logic [1:0] byte_lane_mask(input logic hi_byte);
      return hi_byte ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port of the scoreboarded register file.
// Ports:
//   clk, reset               : core clock, async active-high reset
//   regs, busy               : current storage and scoreboard from the top
//   wr_en/wr_phys/wr_lanes/wr_data : same-cycle write, already decoded and
//                              byte-aligned, used for write-before-read bypass
//   reserve_en/reserve_sel   : same-cycle reservation (keeps rd_busy asserted)
//   rd_sel/rd_is_8_bit       : read request
//   rd_val                   : registered read data (1-cycle latency)
//   rd_busy                  : combinational stall indication
module regfile_read_port import regfile_pkg::*; #(
   parameter int unsigned NUM_REGS   = 8,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned SEL_W      = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [DATA_WIDTH-1:0]   regs [NUM_REGS],
   input  logic [NUM_REGS-1:0]     busy,
   input  logic                    wr_en,
   input  logic [SEL_W-1:0]        wr_phys,
   input  logic [DATA_WIDTH/8-1:0] wr_lanes,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic                    reserve_en,
   input  logic [SEL_W-1:0]        reserve_sel,
   input  logic [SEL_W-1:0]        rd_sel,
   input  logic                    rd_is_8_bit,
   output logic [DATA_WIDTH-1:0]   rd_val,
   output logic                    rd_busy
);

   localparam int unsigned NB = DATA_WIDTH / 8;

   logic [SEL_W-1:0]      rd_phys;
   logic                  wr_hit;
   logic [DATA_WIDTH-1:0] merged;
   logic [DATA_WIDTH-1:0] rd_val_d, rd_val_q;

   always_comb begin
      rd_phys = SEL_W'(phys_reg(32'(rd_sel), rd_is_8_bit, SEL_W));
      wr_hit  = wr_en && (wr_phys == rd_phys);

      // Bypass merges only the byte lanes actually being written.
      merged = regs[rd_phys];
      for (int unsigned b = 0; b < NB; b++) begin
         if (wr_hit && wr_lanes[b]) begin
            merged[8*b +: 8] = wr_data[8*b +: 8];
         end
      end

      rd_val_d = '0;
      if (rd_is_8_bit) begin
         rd_val_d[7:0] = rd_sel[SEL_W-1] ? merged[15:8] : merged[7:0];
      end else begin
         rd_val_d = merged;
      end

      // A writeback unblocks the read unless the same register is re-reserved.
      rd_busy = busy[rd_phys] & ~(wr_hit & ~(reserve_en && (reserve_sel == rd_phys)));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_val_q <= '0;
      end else begin
         rd_val_q <= rd_val_d;
      end
   end

   assign rd_val = rd_val_q;

endmodule

// File: rtl/scoreboarded_register_file.sv
// General-purpose register file with 8-bit sub-register aliasing, registered
// reads with write-before-read bypass, and a per-register busy scoreboard.
// Ports:
//   clk, reset                  : core clock, async active-high reset
//   rd_sel/rd_is_8_bit [ports]  : read requests; rd_val registered, rd_busy comb
//   wr_sel/wr_is_8_bit/wr_val/wr_en : writeback; wr_en also clears busy
//   reserve_en/reserve_sel      : mark a full register busy (set beats clear)
//   busy_vec                    : scoreboard state
// Optional feature (macro REGFILE_DEBUG_EN): dbg_sel/dbg_rd_val combinational
// full-register read, dbg_wr_en/dbg_wr_val full-register write with lower
// priority than wr_en; does not affect scoreboard or bypass.
module scoreboarded_register_file import regfile_pkg::*; #(
   parameter  int unsigned NUM_REGS     = 8,
   parameter  int unsigned DATA_WIDTH   = 16,
   parameter  int unsigned NUM_RD_PORTS = 2,
   localparam int unsigned SEL_W        = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [SEL_W-1:0]      rd_sel      [NUM_RD_PORTS],
   input  logic                  rd_is_8_bit [NUM_RD_PORTS],
   output logic [DATA_WIDTH-1:0] rd_val      [NUM_RD_PORTS],
   output logic                  rd_busy     [NUM_RD_PORTS],
   input  logic [SEL_W-1:0]      wr_sel,
   input  logic                  wr_is_8_bit,
   input  logic [DATA_WIDTH-1:0] wr_val,
   input  logic                  wr_en,
   input  logic                  reserve_en,
   input  logic [SEL_W-1:0]      reserve_sel,
   output logic [NUM_REGS-1:0]   busy_vec
`ifdef REGFILE_DEBUG_EN
   ,
   input  logic [SEL_W-1:0]      dbg_sel,
   output logic [DATA_WIDTH-1:0] dbg_rd_val,
   input  logic                  dbg_wr_en,
   input  logic [DATA_WIDTH-1:0] dbg_wr_val
`endif
);

   localparam int unsigned NB = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [NUM_REGS-1:0]   busy_d, busy_q;
   logic [SEL_W-1:0]      wr_phys;
   logic [NB-1:0]         wr_lanes;
   logic [DATA_WIDTH-1:0] wr_data;

   always_comb begin
      wr_phys  = SEL_W'(phys_reg(32'(wr_sel), wr_is_8_bit, SEL_W));
      wr_lanes = wr_is_8_bit ? NB'(byte_lane_mask(wr_sel[SEL_W-1])) : '1;
      // Replicating the byte lets the lane mask alone place it.
      wr_data  = wr_is_8_bit ? {NB{wr_val[7:0]}} : wr_val;

      regs_d = regs_q;
`ifdef REGFILE_DEBUG_EN
      if (dbg_wr_en) begin
         regs_d[dbg_sel] = dbg_wr_val;
      end
`endif
      if (wr_en) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (wr_lanes[b]) begin
               regs_d[wr_phys][8*b +: 8] = wr_data[8*b +: 8];
            end
         end
      end

      busy_d = busy_q;
      if (wr_en) begin
         busy_d[wr_phys] = 1'b0;
      end
      if (reserve_en) begin
         busy_d[reserve_sel] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   assign busy_vec = busy_q;

`ifdef REGFILE_DEBUG_EN
   assign dbg_rd_val = regs_q[dbg_sel];
`endif

   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
      regfile_read_port #(
         .NUM_REGS   (NUM_REGS),
         .DATA_WIDTH (DATA_WIDTH),
         .SEL_W      (SEL_W)
      ) u_port (
         .clk         (clk),
         .reset       (reset),
         .regs        (regs_q),
         .busy        (busy_q),
         .wr_en       (wr_en),
         .wr_phys     (wr_phys),
         .wr_lanes    (wr_lanes),
         .wr_data     (wr_data),
         .reserve_en  (reserve_en),
         .reserve_sel (reserve_sel),
         .rd_sel      (rd_sel[p]),
         .rd_is_8_bit (rd_is_8_bit[p]),
         .rd_val      (rd_val[p]),
         .rd_busy     (rd_busy[p])
      );
   end

endmodule

// File: tb/tb_scoreboarded_register_file.sv
// Bench for scoreboarded_register_file: a default instance (8x16, 2 ports) and
// a wide instance (16x32, 3 ports) driven side by side. Optional debug port
// exercised when REGFILE_DEBUG_EN is defined.
module tb_scoreboarded_register_file;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // default instance
   logic [2:0]  a_rd_sel [2];
   logic        a_rd8 [2];
   logic [15:0] a_rd_val [2];
   logic        a_rd_busy [2];
   logic [2:0]  a_wr_sel, a_res_sel;
   logic        a_wr8, a_wr_en, a_res_en;
   logic [15:0] a_wr_val;
   logic [7:0]  a_busy_vec;

   // wide instance
   logic [3:0]  b_rd_sel [3];
   logic        b_rd8 [3];
   logic [31:0] b_rd_val [3];
   logic        b_rd_busy [3];
   logic [3:0]  b_wr_sel, b_res_sel;
   logic        b_wr8, b_wr_en, b_res_en;
   logic [31:0] b_wr_val;
   logic [15:0] b_busy_vec;

`ifdef REGFILE_DEBUG_EN
   logic [2:0]  a_dbg_sel = '0;
   logic [15:0] a_dbg_rd_val;
   logic        a_dbg_wr_en = 1'b0;
   logic [15:0] a_dbg_wr_val = '0;
   logic [3:0]  b_dbg_sel = '0;
   logic [31:0] b_dbg_rd_val;
   logic        b_dbg_wr_en = 1'b0;
   logic [31:0] b_dbg_wr_val = '0;
`endif

   scoreboarded_register_file u_a (
      .clk(clk), .reset(reset),
      .rd_sel(a_rd_sel), .rd_is_8_bit(a_rd8), .rd_val(a_rd_val), .rd_busy(a_rd_busy),
      .wr_sel(a_wr_sel), .wr_is_8_bit(a_wr8), .wr_val(a_wr_val), .wr_en(a_wr_en),
      .reserve_en(a_res_en), .reserve_sel(a_res_sel), .busy_vec(a_busy_vec)
`ifdef REGFILE_DEBUG_EN
      , .dbg_sel(a_dbg_sel), .dbg_rd_val(a_dbg_rd_val),
      .dbg_wr_en(a_dbg_wr_en), .dbg_wr_val(a_dbg_wr_val)
`endif
   );

   scoreboarded_register_file #(
      .NUM_REGS(16), .DATA_WIDTH(32), .NUM_RD_PORTS(3)
   ) u_b (
      .clk(clk), .reset(reset),
      .rd_sel(b_rd_sel), .rd_is_8_bit(b_rd8), .rd_val(b_rd_val), .rd_busy(b_rd_busy),
      .wr_sel(b_wr_sel), .wr_is_8_bit(b_wr8), .wr_val(b_wr_val), .wr_en(b_wr_en),
      .reserve_en(b_res_en), .reserve_sel(b_res_sel), .busy_vec(b_busy_vec)
`ifdef REGFILE_DEBUG_EN
      , .dbg_sel(b_dbg_sel), .dbg_rd_val(b_dbg_rd_val),
      .dbg_wr_en(b_dbg_wr_en), .dbg_wr_val(b_dbg_wr_val)
`endif
   );

   typedef struct {
      int unsigned rd_sel [3];
      bit          rd8 [3];
      int unsigned wr_sel;
      bit          wr8;
      logic [31:0] wr_val;
      bit          wr_en;
      bit          res_en;
      int unsigned res_sel;
   } stim_t;

   typedef struct {
      logic [31:0] rd [2][3];
      logic [15:0] busy [2];
   } exp_t;

   // reference model: index 0 = default instance, 1 = wide instance
   logic [31:0] m_regs [2][16];
   logic [15:0] m_busy [2];
   exp_t        exp_q [$];
   int          checks = 0;
   int          errors = 0;

   function automatic int unsigned nregs(int c);  return (c != 0) ? 16 : 8; endfunction
   function automatic int unsigned nports(int c); return (c != 0) ? 3 : 2;  endfunction
   function automatic logic [31:0] dmask(int c);  return (c != 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF; endfunction

   // 8-bit selectors name a byte of the lower half of the file
   function automatic int unsigned m_phys(int c, int unsigned sel, bit is8);
      return is8 ? (sel % (nregs(c) / 2)) : sel;
   endfunction
   function automatic int unsigned m_shift(int c, int unsigned sel, bit is8);
      return (is8 && sel >= nregs(c) / 2) ? 8 : 0;
   endfunction

   function void chk(string nm, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endfunction

   function automatic stim_t idle();
      stim_t s;
      for (int i = 0; i < 3; i++) begin s.rd_sel[i] = 0; s.rd8[i] = 1'b0; end
      s.wr_sel = 0; s.wr8 = 1'b0; s.wr_val = '0; s.wr_en = 1'b0;
      s.res_en = 1'b0; s.res_sel = 0;
      return s;
   endfunction

   function automatic stim_t rand_stim(int c);
      stim_t s;
      int unsigned n;
      n = nregs(c);
      for (int i = 0; i < 3; i++) begin
         s.rd_sel[i] = $urandom_range(n - 1);
         s.rd8[i]    = ($urandom_range(1) == 1);
      end
      s.wr_sel  = $urandom_range(n - 1);
      s.wr8     = ($urandom_range(1) == 1);
      s.wr_val  = $urandom & dmask(c);
      s.wr_en   = ($urandom_range(1) == 1);
      s.res_en  = ($urandom_range(2) == 0);
      s.res_sel = $urandom_range(n - 1);
      return s;
   endfunction

   task automatic drive(stim_t sa, stim_t sb);
      for (int i = 0; i < 2; i++) begin a_rd_sel[i] = 3'(sa.rd_sel[i]); a_rd8[i] = sa.rd8[i]; end
      a_wr_sel = 3'(sa.wr_sel); a_wr8 = sa.wr8; a_wr_val = 16'(sa.wr_val);
      a_wr_en = sa.wr_en; a_res_en = sa.res_en; a_res_sel = 3'(sa.res_sel);
      for (int i = 0; i < 3; i++) begin b_rd_sel[i] = 4'(sb.rd_sel[i]); b_rd8[i] = sb.rd8[i]; end
      b_wr_sel = 4'(sb.wr_sel); b_wr8 = sb.wr8; b_wr_val = sb.wr_val;
      b_wr_en = sb.wr_en; b_res_en = sb.res_en; b_res_sel = 4'(sb.res_sel);
   endtask

   // Drive one cycle at negedge, check comb rd_busy, queue the post-edge state.
   task automatic cycle(stim_t sa, stim_t sb, bit rst);
      stim_t       s [2];
      exp_t        e;
      logic [15:0] bnext;
      int unsigned wp, rp, sh;
      logic        act_busy;
      @(negedge clk);
      drive(sa, sb);
      reset = rst;
      #1;
      s[0] = sa; s[1] = sb;
      for (int c = 0; c < 2; c++) begin
         e.busy[c] = '0;
         for (int p = 0; p < 3; p++) e.rd[c][p] = '0;
      end
      if (rst) begin
         for (int c = 0; c < 2; c++) begin
            m_busy[c] = '0;
            for (int r = 0; r < 16; r++) m_regs[c][r] = '0;
         end
         for (int p = 0; p < 2; p++) chk($sformatf("rst_a_rd_val%0d", p), 32'(a_rd_val[p]), 32'h0);
         for (int p = 0; p < 3; p++) chk($sformatf("rst_b_rd_val%0d", p), b_rd_val[p], 32'h0);
         chk("rst_a_busy_vec", 32'(a_busy_vec), 32'h0);
         chk("rst_b_busy_vec", 32'(b_busy_vec), 32'h0);
      end else begin
         for (int c = 0; c < 2; c++) begin
            bnext = m_busy[c];
            wp = m_phys(c, s[c].wr_sel, s[c].wr8);
            if (s[c].wr_en)  bnext[wp] = 1'b0;
            if (s[c].res_en) bnext[s[c].res_sel] = 1'b1;
            if (s[c].wr_en) begin
               sh = m_shift(c, s[c].wr_sel, s[c].wr8);
               if (s[c].wr8)
                  m_regs[c][wp] = (m_regs[c][wp] & ~(32'hFF << sh)) | ((s[c].wr_val & 32'hFF) << sh);
               else
                  m_regs[c][wp] = s[c].wr_val & dmask(c);
            end
            for (int p = 0; p < int'(nports(c)); p++) begin
               rp = m_phys(c, s[c].rd_sel[p], s[c].rd8[p]);
               // stalled iff busy now and still busy after this cycle's update
               act_busy = (c != 0) ? b_rd_busy[p] : a_rd_busy[p];
               chk($sformatf("%s_rd_busy%0d", (c != 0) ? "b" : "a", p),
                   32'(act_busy), 32'(m_busy[c][rp] & bnext[rp]));
               sh = m_shift(c, s[c].rd_sel[p], s[c].rd8[p]);
               e.rd[c][p] = (m_regs[c][rp] >> sh) & (s[c].rd8[p] ? 32'hFF : dmask(c));
            end
            m_busy[c] = bnext;
            e.busy[c] = bnext;
         end
      end
      exp_q.push_back(e);
   endtask

   // monitor: one expected entry per clock edge after it was queued
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int p = 0; p < 2; p++) chk($sformatf("a_rd_val%0d", p), 32'(a_rd_val[p]), e.rd[0][p]);
            for (int p = 0; p < 3; p++) chk($sformatf("b_rd_val%0d", p), b_rd_val[p], e.rd[1][p]);
            chk("a_busy_vec", 32'(a_busy_vec), 32'(e.busy[0]));
            chk("b_busy_vec", 32'(b_busy_vec), 32'(e.busy[1]));
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      stim_t sa, sb;
      drive(idle(), idle());
      for (int c = 0; c < 2; c++) begin
         m_busy[c] = '0;
         for (int r = 0; r < 16; r++) m_regs[c][r] = '0;
      end
      @(posedge clk); #1;
      chk("init_a_rd_val0", 32'(a_rd_val[0]), 32'h0);
      chk("init_a_busy_vec", 32'(a_busy_vec), 32'h0);
      cycle(idle(), idle(), 1'b0);

      // 8-bit aliasing
      sa = idle(); sa.wr_en = 1; sa.wr_sel = 0; sa.wr_val = 32'h1234; cycle(sa, idle(), 0);
      sa = idle(); sa.wr_en = 1; sa.wr8 = 1; sa.wr_sel = 4; sa.wr_val = 32'hAB; cycle(sa, idle(), 0);
      sa = idle(); sa.rd_sel[0] = 0; sa.rd_sel[1] = 0; sa.rd8[1] = 1; cycle(sa, idle(), 0);
      @(posedge clk); #1;
      chk("alias_ax", 32'(a_rd_val[0]), 32'hAB34);
      chk("alias_al", 32'(a_rd_val[1]), 32'h0034);

      // write-before-read bypass
      sa = idle(); sa.wr_en = 1; sa.wr_sel = 0; sa.wr_val = 32'hBEEF;
      sa.rd_sel[0] = 0; sa.rd_sel[1] = 4; sa.rd8[1] = 1; cycle(sa, idle(), 0);
      @(posedge clk); #1;
      chk("bypass_ax", 32'(a_rd_val[0]), 32'hBEEF);
      chk("bypass_ah", 32'(a_rd_val[1]), 32'h00BE);

      // byte-granular bypass merge
      sa = idle(); sa.wr_en = 1; sa.wr_sel = 0; sa.wr_val = 32'h1234; cycle(sa, idle(), 0);
      sa = idle(); sa.wr_en = 1; sa.wr8 = 1; sa.wr_sel = 0; sa.wr_val = 32'h77; cycle(sa, idle(), 0);
      @(posedge clk); #1;
      chk("merge_ax", 32'(a_rd_val[0]), 32'h1277);

      // scoreboard on BX / BL
      sa = idle(); sa.res_en = 1; sa.res_sel = 3; sa.rd_sel[1] = 3; sa.rd8[1] = 1; cycle(sa, idle(), 0);
      @(posedge clk); #1;
      chk("sb_reserve_vec", 32'(a_busy_vec), 32'h08);
      sa = idle(); sa.rd_sel[1] = 3; sa.rd8[1] = 1; cycle(sa, idle(), 0);
      chk("sb_bl_busy", 32'(a_rd_busy[1]), 32'h1);
      sa = idle(); sa.wr_en = 1; sa.wr_sel = 3; sa.wr_val = 32'h5555; sa.rd_sel[1] = 3; sa.rd8[1] = 1;
      cycle(sa, idle(), 0);
      chk("sb_wb_unblocks", 32'(a_rd_busy[1]), 32'h0);
      @(posedge clk); #1;
      chk("sb_cleared_vec", 32'(a_busy_vec), 32'h00);
      sa = idle(); sa.res_en = 1; sa.res_sel = 3; cycle(sa, idle(), 0);
      sa = idle(); sa.res_en = 1; sa.res_sel = 3; sa.wr_en = 1; sa.wr_sel = 3; sa.wr_val = 32'h6666;
      sa.rd_sel[1] = 3; sa.rd8[1] = 1; cycle(sa, idle(), 0);
      chk("sb_rereserve_busy", 32'(a_rd_busy[1]), 32'h1);
      @(posedge clk); #1;
      chk("sb_set_wins_vec", 32'(a_busy_vec), 32'h08);

      // wide instance: r15 and three simultaneous bypassed reads
      sb = idle(); sb.wr_en = 1; sb.wr_sel = 15; sb.wr_val = 32'hDEADBEEF; cycle(idle(), sb, 0);
      sb = idle(); for (int i = 0; i < 3; i++) sb.rd_sel[i] = 15; cycle(idle(), sb, 0);
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) chk($sformatf("wide_r15_%0d", i), b_rd_val[i], 32'hDEADBEEF);
      sb = idle(); sb.wr_en = 1; sb.wr_sel = 5; sb.wr_val = 32'hCAFEF00D;
      sb.rd_sel[0] = 5; sb.rd_sel[1] = 13; sb.rd8[1] = 1; sb.rd_sel[2] = 5; sb.rd8[2] = 1;
      cycle(idle(), sb, 0);
      @(posedge clk); #1;
      chk("wide_byp_full", b_rd_val[0], 32'hCAFEF00D);
      chk("wide_byp_hi",   b_rd_val[1], 32'h000000F0);
      chk("wide_byp_lo",   b_rd_val[2], 32'h0000000D);

`ifdef REGFILE_DEBUG_EN
      cycle(idle(), idle(), 0);
      b_dbg_sel = 4'd3; b_dbg_wr_val = 32'h0BADC0DE; b_dbg_wr_en = 1'b1;
      @(posedge clk); #1;
      b_dbg_wr_en = 1'b0;
      m_regs[1][3] = 32'h0BADC0DE;
      chk("dbg_r3", b_dbg_rd_val, 32'h0BADC0DE);
`endif

      // randomized traffic, then reset mid-run with reservations pending
      for (int n = 0; n < 300; n++) cycle(rand_stim(0), rand_stim(1), 0);
      sa = idle(); sa.res_en = 1; sa.res_sel = 6;
      sb = idle(); sb.res_en = 1; sb.res_sel = 12;
      cycle(sa, sb, 0);
      cycle(idle(), idle(), 1);
      cycle(idle(), idle(), 0);
      for (int n = 0; n < 300; n++) cycle(rand_stim(0), rand_stim(1), 0);

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
